// File: rtl/d_mem_arbiter.sv
// Two-port arbiter in front of the combinational data memory: one access per grant,
// serviced in a single SERVE cycle, round-robin or core-priority with a starvation guard.
module d_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] ReadData
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state;
  logic          owner;       // 0 = A, 1 = B
  logic          last_owner;  // 0 = A, 1 = B
  logic [CW-1:0] starve_cnt;
  logic          tie_to_a;

  // A tie goes to A when B owned last (round-robin) or while B is not yet starved.
  always_comb begin
    tie_to_a = 1'b0;
    if (PRIO_MODE == 0)
      tie_to_a = last_owner;
    else
      tie_to_a = (starve_cnt != CW'(STARVE_LIMIT));
    a_gnt = !RST && (state == IDLE) && a_req && (!b_req || tie_to_a);
    b_gnt = !RST && (state == IDLE) && b_req && (!a_req || !tie_to_a);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      starve_cnt <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (a_gnt || b_gnt) begin
            owner      <= b_gnt;
            last_owner <= b_gnt;
            Address    <= b_gnt ? b_addr  : a_addr;
            WriteData  <= b_gnt ? b_wdata : a_wdata;
            MemWrite   <= b_gnt ? b_we    : a_we;
            MemRead    <= b_gnt ? !b_we   : !a_we;
            state      <= SERVE;
            if (a_gnt && b_req) begin
              if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        SERVE: begin
          // MemRead still marks a load here, so only loads overwrite rdata.
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          state    <= IDLE;
          if (owner) begin
            b_rvalid <= 1'b1;
            if (MemRead) b_rdata <= ReadData;
          end else begin
            a_rvalid <= 1'b1;
            if (MemRead) a_rdata <= ReadData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
